// File: rtl/seven_seg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver_if
// Bundle between the datapath side and the seven-segment scan driver.
//   Datapath -> driver : load, value, dp_in, blank_lz, enable
//   Driver -> pins     : seg, dp, an, frame_done
// Modports:
//   master - the datapath/register-file side (drives data, watches pins)
//   slave  - the scan driver itself
// ---------------------------------------------------------------------------
interface seven_seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic                  enable;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output load, value, dp_in, blank_lz, enable,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_lz, enable,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed driver for a DIGITS-wide seven-segment display. A packed
// hex value, decimal-point mask and leading-zero-blank flag are captured into
// shadow registers on load; one digit is lit at a time for SCAN_DIV cycles,
// its nibble decoded to segments {a..g} (seg[6]=a). All pins are registered.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset (overrides load and enable)
//   disp_if  - slave modport: load/value/dp_in/blank_lz/enable in,
//              seg/dp/an/frame_done out
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_seg_scan_driver_if.slave  disp_if
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Pin levels meaning "off" once polarity is applied.
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Hex nibble to active-high abcdefg segments.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      4'hF:    s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Shadow, scan and output registers
  logic [4*DIGITS-1:0] val_q,   val_d;
  logic [DIGITS-1:0]   dpm_q,   dpm_d;
  logic                blz_q,   blz_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [6:0]          seg_q,   seg_d;
  logic                dp_q,    dp_d;
  logic [DIGITS-1:0]   an_q,    an_d;
  logic                fd_q,    fd_d;

  // Per-digit view of the shadow data
  logic [4*DIGITS-1:0] val_shift_s;
  logic [DIGITS-1:0]   dp_shift_s;
  logic [DIGITS-1:0]   an_onehot_s;
  logic [6:0]          seg_lit_s;
  logic                blank_s;

  // Select the active digit's nibble, dp and blanking condition.
  always_comb begin
    // Shifting the digit down to bit 0 leaves zero exactly when this digit
    // and every more-significant digit are zero: the leading-zero test.
    val_shift_s = val_q >> {idx_q, 2'b00};
    dp_shift_s  = dpm_q >> idx_q;
    an_onehot_s = DIGITS'(1) << idx_q;
    seg_lit_s   = seg_decode(val_shift_s[3:0]);
    blank_s     = blz_q && (idx_q != '0) && (val_shift_s == '0);
  end

  // Shadow capture, divider/index advance and next pin values.
  always_comb begin
    val_d = val_q;
    dpm_d = dpm_q;
    blz_d = blz_q;
    div_d = div_q;
    idx_d = idx_q;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    fd_d  = 1'b0;

    if (disp_if.load) begin
      val_d = disp_if.value;
      dpm_d = disp_if.dp_in;
      blz_d = disp_if.blank_lz;
    end else begin
      val_d = val_q;
    end

    if (disp_if.enable) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        fd_d  = (idx_q == IDX_LAST);
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      // Blanked digits keep their anode slot and dp so scan timing is unchanged.
      an_d  = AN_ACTIVE_LOW ? ~an_onehot_s : an_onehot_s;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_shift_s[0] : dp_shift_s[0];
      if (blank_s) begin
        seg_d = SEG_OFF;
      end else begin
        seg_d = SEG_ACTIVE_LOW ? ~seg_lit_s : seg_lit_s;
      end
    end else begin
      // Dark and frozen: divider and index keep their defaults (hold).
      fd_d = 1'b0;
    end
  end

  // State and pin registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      dpm_q <= '0;
      blz_q <= 1'b0;
      div_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
      fd_q  <= 1'b0;
    end else begin
      val_q <= val_d;
      dpm_q <= dpm_d;
      blz_q <= blz_d;
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      fd_q  <= fd_d;
    end
  end

  assign disp_if.seg        = seg_q;
  assign disp_if.dp         = dp_q;
  assign disp_if.an         = an_q;
  assign disp_if.frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_driver
// Two drivers (active-high and fully inverted polarity) share one stimulus.
// Each cycle a reference model predicts the pins, pushes the prediction into
// a scoreboard queue, and the entry is popped and compared after the edge.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus_a ();
  seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus_b ();

  assign bus_b.load     = bus_a.load;
  assign bus_b.value    = bus_a.value;
  assign bus_b.dp_in    = bus_a.dp_in;
  assign bus_b.blank_lz = bus_a.blank_lz;
  assign bus_b.enable   = bus_a.enable;

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .disp_if(bus_a)
  );

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .disp_if(bus_b)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_blz;
  int          m_div;
  int          m_idx;

  int err_cnt = 0;
  int chk_cnt = 0;
  int fd_seen = 0;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
      4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  4'hF: return 7'h47;
      default: return 7'h00;
    endcase
  endfunction

  // Predict this edge, advance the model, clock, then compare both DUTs.
  task automatic step();
    exp_t        e;
    logic [15:0] sh;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        dp_n;
    e = '0;
    if (rst) begin
      m_val = 16'h0; m_dp = 4'h0; m_blz = 1'b0; m_div = 0; m_idx = 0;
    end else begin
      if (bus_a.enable) begin
        sh    = m_val >> (4 * m_idx);
        e.an  = 4'(1 << m_idx);
        e.seg = (m_blz && (m_idx != 0) && (sh == 16'h0)) ? 7'h00 : ref_seg(sh[3:0]);
        e.dp  = m_dp[m_idx];
        e.fd  = (m_div == SCAN_DIV - 1) && (m_idx == DIGITS - 1);
        if (m_div == SCAN_DIV - 1) begin
          m_div = 0;
          m_idx = (m_idx + 1) % DIGITS;
        end else begin
          m_div++;
        end
      end
      if (bus_a.load) begin
        m_val = bus_a.value; m_dp = bus_a.dp_in; m_blz = bus_a.blank_lz;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    seg_n = ~e.seg;
    an_n  = ~e.an;
    dp_n  = ~e.dp;
    check_value("seg",    32'(bus_a.seg),        32'(e.seg));
    check_value("dp",     32'(bus_a.dp),         32'(e.dp));
    check_value("an",     32'(bus_a.an),         32'(e.an));
    check_value("fd",     32'(bus_a.frame_done), 32'(e.fd));
    check_value("seg_lo", 32'(bus_b.seg),        32'(seg_n));
    check_value("dp_lo",  32'(bus_b.dp),         32'(dp_n));
    check_value("an_lo",  32'(bus_b.an),         32'(an_n));
    check_value("fd_lo",  32'(bus_b.frame_done), 32'(e.fd));
    if (bus_a.frame_done) fd_seen++;
  endtask

  task automatic load_run(input logic [15:0] v, input logic [3:0] d, input logic b, input int n);
    bus_a.load = 1'b1; bus_a.value = v; bus_a.dp_in = d; bus_a.blank_lz = b;
    step();
    bus_a.load = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus_a.load = 1'b0; bus_a.value = 16'h0; bus_a.dp_in = 4'h0;
    bus_a.blank_lz = 1'b0; bus_a.enable = 1'b0;
    step();
    step();
    check_value("rst_seg",    32'(bus_a.seg),        32'h00);
    check_value("rst_an",     32'(bus_a.an),         32'h0);
    check_value("rst_dp",     32'(bus_a.dp),         32'h0);
    check_value("rst_fd",     32'(bus_a.frame_done), 32'h0);
    check_value("rst_seg_lo", 32'(bus_b.seg),        32'h7F);
    check_value("rst_an_lo",  32'(bus_b.an),         32'hF);
    check_value("rst_dp_lo",  32'(bus_b.dp),         32'h1);

    // Basic scan of 12AF: 4 cycles per digit, frame_done every 16 cycles.
    rst = 1'b0;
    bus_a.enable = 1'b1;
    bus_a.load = 1'b1; bus_a.value = 16'h12AF; bus_a.dp_in = 4'h0; bus_a.blank_lz = 1'b0;
    step();
    bus_a.load = 1'b0;
    step();
    check_value("scan_d0_seg", 32'(bus_a.seg), 32'h47);
    check_value("scan_d0_an",  32'(bus_a.an),  32'h1);
    fd_seen = 0;
    for (int k = 2; k < 34; k++) begin
      step();
      if (k == 5) begin
        check_value("scan_d1_seg", 32'(bus_a.seg), 32'h77);
        check_value("scan_d1_an",  32'(bus_a.an),  32'h2);
      end else if (k == 9) begin
        check_value("scan_d2_seg", 32'(bus_a.seg), 32'h6D);
        check_value("scan_d2_an",  32'(bus_a.an),  32'h4);
      end else if (k == 13) begin
        check_value("scan_d3_seg", 32'(bus_a.seg), 32'h30);
        check_value("scan_d3_an",  32'(bus_a.an),  32'h8);
      end
    end
    check_value("frame_cnt", 32'(fd_seen), 32'd2);

    // Leading-zero blanking with dp on a blanked digit, then without blanking.
    load_run(16'h0050, 4'b0100, 1'b1, 20);
    load_run(16'h0050, 4'b0100, 1'b0, 20);
    load_run(16'h0000, 4'b0000, 1'b1, 20);

    // Freeze mid-slot at index 2, count 1.
    load_run(16'h12AF, 4'b0000, 1'b0, 0);
    guard = 0;
    while (!(m_idx == 2 && m_div == 1) && guard < 64) begin
      step();
      guard++;
    end
    check_value("seek_idx2", 32'(guard < 64), 32'd1);
    bus_a.enable = 1'b0;
    step();
    check_value("dark_an",  32'(bus_a.an),  32'h0);
    check_value("dark_seg", 32'(bus_a.seg), 32'h00);
    for (int i = 0; i < 9; i++) step();
    bus_a.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("resume_d2", 32'(bus_a.an), 32'h4);
    end
    step();
    check_value("resume_d3", 32'(bus_a.an), 32'h8);

    // Load on the same edge as a digit advance; nibble 8 everywhere.
    guard = 0;
    while (m_div != SCAN_DIV - 1 && guard < 16) begin
      step();
      guard++;
    end
    check_value("seek_term", 32'(guard < 16), 32'd1);
    load_run(16'h8888, 4'b0000, 1'b0, 1);
    check_value("adv_load_seg",    32'(bus_a.seg), 32'h7F);
    check_value("adv_load_seg_lo", 32'(bus_b.seg), 32'h00);
    for (int i = 0; i < 8; i++) step();

    // Reset mid-frame.
    guard = 0;
    while (m_idx != 1 && guard < 32) begin
      step();
      guard++;
    end
    rst = 1'b1;
    step();
    check_value("midrst_an", 32'(bus_a.an),         32'h0);
    check_value("midrst_fd", 32'(bus_a.frame_done), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Random mix of loads, enable gaps and occasional reset.
    for (int i = 0; i < 300; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      bus_a.load     = ($urandom_range(0, 3) == 0);
      bus_a.value    = 16'($urandom);
      bus_a.dp_in    = 4'($urandom);
      bus_a.blank_lz = 1'($urandom);
      bus_a.enable   = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for a DIGITS-wide common-segment seven-segment display; successor to the single-digit combinational hex decoder.
- Captures a packed hex value into a shadow register on a load strobe, scans one digit at a time at a programmable rate, and decodes each nibble to segments.
- Adds decimal points, leading-zero blanking, selectable output polarity, scan enable and a frame-complete pulse.
- Sits between the datapath/register file and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..16); digit 0 is least significant.
- SCAN_DIV, 1000, clock cycles each digit stays lit (>=1).
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 0, 1 inverts an at the pins.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture value, dp_in and blank_lz into the shadow registers this cycle.
- value  in  4*DIGITS  packed nibbles; nibble i = value[4i+3:4i] drives digit i.
- dp_in  in  DIGITS  decimal point request per digit.
- blank_lz  in  1  leading-zero blanking enable (captured on load).
- enable  in  1  1 = scanning; 0 = display dark, scan state frozen.
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a ... seg[0]=g.
- dp  out  1  decimal point of the active digit.
- an  out  DIGITS  one-hot digit select.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset: shadow value/dp/blank_lz = 0, div counter = 0, digit index = 0. Outputs are registered and driven inactive: seg and dp off, an all off (polarity applied), frame_done = 0.
- Shadow capture: on load, shadow <= inputs at the clock edge. Outputs reflect the new data on the next output update, i.e. one cycle after the load edge. Displayed data never changes without load.
- Divider: when enable=1, counts 0..SCAN_DIV-1.
  - At terminal count it returns to 0 and the index advances by 1, wrapping DIGITS-1 -> 0.
  - frame_done = 1 for exactly the cycle after the wrap edge. When SCAN_DIV=1, the index advances every cycle.
- Output register: each cycle, an <= one-hot(index), seg <= decode(shadow nibble[index]), dp <= shadow_dp[index]. Latency from an index change to the pins is 1 cycle.
- Decode, hex, abcdefg, active-high:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- Leading-zero blanking: when shadow blank_lz=1, digit i is blanked if every nibble j >= i is 0, for i >= 1. Digit 0 is never blanked.
  - Blanked digit: seg all off, but dp still honours shadow_dp.
  - an still selects the blanked digit, so scan timing is unchanged.
- enable=0: divider and index hold their values. On the next edge an, seg and dp go inactive, and frame_done = 0. When enable returns to 1, scanning resumes from the held index and count.
- Simultaneous events:
  - load with a digit advance: the new shadow and new index are both used on the next output update.
  - rst overrides load and enable.
- Polarity: inversion is applied only at the final output register. Internal state is polarity-independent.
- Reset asserted mid-scan: returns to the reset state on that edge, with no partial frame_done.

Test Plan:
- DIGITS=4, SCAN_DIV=4: rst for 2 cycles; check seg=00, an=0, dp=0, frame_done=0. Release, load value=16'h12AF, enable=1. Expect an=0001/seg=47, then 0010/77, 0100/6D, 1000/30, each held 4 cycles, and a frame_done pulse every 16 cycles.
- Load 16'h0050 with blank_lz=1 and dp_in=4'b0100. Digits 3 and 2 are blanked; digit 2 shows dp=1. Digit 1 shows 5B, digit 0 shows 7E. With blank_lz=0, digit 3 shows 7E.
- Load 16'h0000 with blank_lz=1: digit 0 shows 7E; digits 1-3 are seg=00.
- Drop enable mid-slot at index 2, count 1, for 10 cycles: outputs go dark the next cycle. On re-enable, digit 2 is lit for the remaining 3 cycles, then digit 3.
- SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, value nibble 8: seg=00, and an shows the active digit as 0 with the others 1. During reset seg=7F, an all 1, dp=1.
- Assert load on the same edge as the digit advance: the next digit shows the new nibble immediately. Assert rst mid-frame: an=0 next cycle and frame_done stays 0.
